load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Processor-side initiator for the DataMemory word interface (Address, WriteData, MemWrite, MemRead, ReadData); sits between the MEM pipeline stage and DataMemory.
- Executes MIPS LW/LH/LHU/LB/LBU/SW/SH/SB as word accesses.
- Sub-word loads are extracted and extended from the fetched word; sub-word stores are done as a read-modify-write sequence.
- Uses a request/done handshake so the core can stall while an access is in progress.

Parameters:
ADDR_WIDTH, 32, width of the Addr and MemAddress buses.

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset_n  in  1  synchronous, active-low reset
Req  in  1  access request; sampled only when Ready=1
Op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
Addr  in  ADDR_WIDTH  byte address
StoreData  in  32  store source; SH uses [15:0], SB uses [7:0]
Ready  out  1  1 in IDLE only
Done  out  1  one-cycle completion pulse
LoadData  out  32  load result; valid from Done, held until the next load's Done
Misaligned  out  1  valid with Done; 1 = access aborted
MemAddress  out  ADDR_WIDTH  word address {Addr[ADDR_WIDTH-1:2],2'b00}
MemWriteData  out  32  merged word to memory
MemWrite  out  1  memory write strobe; memory writes on the Clk edge ending the cycle
MemRead  out  1  memory read enable
MemReadData  in  32  memory read data; combinational, same cycle as MemRead

Behaviour:
- Reset values: state IDLE; Ready=1, Done=0, LoadData=0, Misaligned=0, MemRead=0, MemWrite=0, MemAddress=0, MemWriteData=0.
- Reset mid-operation abandons the access: no MemWrite in any cycle after the reset edge, and no Done.
- States: IDLE, READ, WRITE, RESP. Memory strobes are Moore outputs of the state register.
- IDLE:
  - Req=1 latches Op, Addr and StoreData.
  - Next state: READ for loads, SH and SB; WRITE for SW; RESP directly if misaligned.
  - Req while not Ready is ignored and is not queued.
- READ:
  - MemRead=1; MemReadData is captured into the word register on the edge.
  - Next state: RESP for loads; WRITE for SH/SB.
- WRITE:
  - MemWrite=1 for exactly one cycle.
  - MemWriteData: for SW, StoreData; for SH/SB, the captured word with the addressed lane replaced.
  - Next state: RESP.
- RESP: Done=1 and LoadData updated (loads only). Next state IDLE; Ready=1 the following cycle.
- Latency from the accept edge to Done:
  - LW/LH/LHU/LB/LBU: 2 cycles.
  - SW: 2 cycles.
  - SH/SB: 3 cycles.
  - Misaligned: 1 cycle.
- Byte lanes are big-endian: offset 0 = bits [31:24], offset 3 = [7:0]; halfword offset 0 = [31:16], offset 2 = [15:0].
- Load extension: LH/LB sign-extend to 32 bits; LHU/LBU zero-extend.
- Alignment rule: a word access needs Addr[1:0]=00; a halfword access needs Addr[0]=0; a byte access is always aligned.
- MemAddress and MemWriteData hold their last values in IDLE and RESP; MemRead=MemWrite=0 outside READ/WRITE.
- Back-to-back: Req held high with new operands is accepted in the first Ready=1 cycle after Done.

Optional Feature:
MISALIGN_CHECK_EN
- Defined:
  - Misaligned requests skip the memory entirely: no MemRead or MemWrite.
  - They go IDLE->RESP with Done=1 and Misaligned=1; LoadData is unchanged.
- Undefined:
  - Misaligned is tied to 0.
  - Word accesses ignore Addr[1:0]; halfword accesses ignore Addr[0].
  - All requests follow the normal paths.

Test Plan:
- Mem[0x10]=0x11223344; LW 0x10 -> exactly one MemRead cycle at MemAddress 0x10; Done 2 cycles after accept; LoadData=0x11223344; Misaligned=0.
- Mem[0x20]=0x80FF7F01:
  - LB 0x20 -> 0xFFFFFF80.
  - LBU 0x20 -> 0x00000080.
  - LH 0x22 -> 0x00007F01.
  - LH 0x20 -> 0xFFFF80FF.
- Mem[0x10]=0x11223344; SB 0x11 StoreData=0x000000AB -> one MemRead, then one MemWrite with MemWriteData=0x11AB3344; Done 3 cycles after accept; then LW 0x10 returns 0x11AB3344.
- Mem[0x10]=0x11223344; SH 0x12 StoreData=0xDEADBEEF -> MemWriteData=0x1122BEEF. SW 0x14 StoreData=0xCAFEF00D -> MemWrite only (no MemRead), Done 2 cycles after accept.
- With MISALIGN_CHECK_EN: LW 0x12 -> Done 1 cycle after accept, Misaligned=1, MemRead=MemWrite=0 throughout, LoadData unchanged. Without it: LW 0x12 returns Mem[0x10].
- Reset_n=0 for one edge while SB is in READ -> state IDLE, Ready=1, no MemWrite and no Done afterwards, memory word unchanged; also Req pulsed while Ready=0 -> ignored, no extra access.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: MIPS LW/LH/LHU/LB/LBU/SW/SH/SB over a word-wide DataMemory, sub-word stores by read-modify-write.
// Optional: define MISALIGN_CHECK_EN to abort misaligned word/halfword accesses without touching memory.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Req,
  input  logic [2:0]            Op,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           StoreData,
  output logic                  Ready,
  output logic                  Done,
  output logic [31:0]           LoadData,
  output logic                  Misaligned,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [31:0]           MemWriteData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [31:0]           MemReadData
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [2:0] OP_SW = 3'd5;
  localparam logic [2:0] OP_SH = 3'd6;
  logic [1:0]            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           sdata_q, sdata_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic                  mis_q, mis_d;
  logic                  mis_req;
  // big-endian lanes: byte offset 0 is bits [31:24]
  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] off, input logic [31:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? w[15:0] : w[31:16];
    b = 8'(w >> {~off, 3'b000});
    case (op)
      3'd1:    extract = {{16{h[15]}}, h};
      3'd2:    extract = {16'b0, h};
      3'd3:    extract = {{24{b[7]}}, b};
      3'd4:    extract = {24'b0, b};
      default: extract = w;
    endcase
  endfunction
  function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] off,
                                        input logic [31:0] w, input logic [31:0] s);
    logic [31:0] m;
    m = (op == OP_SH) ? (off[1] ? 32'h0000FFFF : 32'hFFFF0000) : (32'h000000FF << {~off, 3'b000});
    merge = (w & ~m) | (((op == OP_SH) ? {2{s[15:0]}} : {4{s[7:0]}}) & m);
  endfunction
`ifdef MISALIGN_CHECK_EN
  assign mis_req = ((Op == 3'd0 || Op == OP_SW) && Addr[1:0] != 2'b00) ||
                   ((Op == 3'd1 || Op == 3'd2 || Op == OP_SH) && Addr[0]);
`else
  assign mis_req = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    sdata_d = sdata_q;
    load_d  = load_q;
    wdata_d = wdata_q;
    maddr_d = maddr_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: if (Req) begin
        op_d    = Op;
        off_d   = Addr[1:0];
        sdata_d = StoreData;
        mis_d   = mis_req;
        if (!mis_req) maddr_d = {Addr[ADDR_WIDTH-1:2], 2'b00};
        if (!mis_req && Op == OP_SW) wdata_d = StoreData;
        state_d = mis_req ? RESP : (Op == OP_SW ? WRITE : READ);
      end
      READ: begin
        if (op_q <= 3'd4) load_d = extract(op_q, off_q, MemReadData);
        else wdata_d = merge(op_q, off_q, MemReadData, sdata_q);
        state_d = (op_q <= 3'd4) ? RESP : WRITE;
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      off_q   <= '0;
      sdata_q <= '0;
      load_q  <= '0;
      wdata_q <= '0;
      maddr_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      sdata_q <= sdata_d;
      load_q  <= load_d;
      wdata_q <= wdata_d;
      maddr_q <= maddr_d;
      mis_q   <= mis_d;
    end
  end
  assign Ready        = state_q == IDLE;
  assign Done         = state_q == RESP;
  assign Misaligned   = Done & mis_q;
  assign MemRead      = state_q == READ;
  assign MemWrite     = state_q == WRITE;
  assign MemAddress   = maddr_q;
  assign MemWriteData = wdata_q;
  assign LoadData     = load_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store sequences against a transaction-level model of the unit and memory.
module tb_load_store_unit;
  logic        Clk = 1'b0, Reset_n = 1'b0, Req = 1'b0;
  logic [2:0]  Op = '0;
  logic [31:0] Addr = '0, StoreData = '0;
  logic        Ready, Done, Misaligned, MemWrite, MemRead;
  logic [31:0] LoadData, MemAddress, MemWriteData, MemReadData;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int          cyc = 0, checks = 0, failures = 0;
  int          acc = -10, rd_cyc = -10, wr_cyc = -10, done_cyc = -10;
  logic [31:0] exp_addr = '0, exp_wdata = '0, ld_prev = '0, ld_model = '0;
  logic        exp_mis = 1'b0, run = 1'b0;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Op(Op), .Addr(Addr), .StoreData(StoreData),
    .Ready(Ready), .Done(Done), .LoadData(LoadData), .Misaligned(Misaligned),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemReadData(MemReadData)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return i == 4 ? 32'h11223344 : i == 8 ? 32'h80FF7F01 : (32'(i) * 32'h01010101) ^ 32'hA5000000;
  endfunction

  always @(posedge Clk) begin
    if (cyc == 0) for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    else if (MemWrite) mem[MemAddress[7:2]] <= MemWriteData;
  end
  assign MemReadData = mem[MemAddress[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge Clk) if (run) begin
    chk("ready", 32'(Ready), 32'(!(cyc > acc && cyc <= done_cyc)));
    chk("done", 32'(Done), 32'(cyc == done_cyc));
    chk("memread", 32'(MemRead), 32'(cyc == rd_cyc));
    chk("memwrite", 32'(MemWrite), 32'(cyc == wr_cyc));
    chk("misaligned", 32'(Misaligned), 32'(cyc == done_cyc && exp_mis));
    chk("loaddata", LoadData, cyc >= done_cyc ? ld_model : ld_prev);
    if (cyc == rd_cyc || cyc == wr_cyc) chk("memaddress", MemAddress, exp_addr);
    if (cyc == wr_cyc) chk("memwritedata", MemWriteData, exp_wdata);
  end

  // Called at posedge+2 of an idle cycle; returns at posedge+2 of the first idle cycle after Done.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input bit hold, input bit abort, input logic [31:0] pin, input int pin_lat);
    logic [31:0] w, v, m;
    int          o, sh, lat;
    bit          mis, word, half, byt;
    Req = 1'b1; Op = op; Addr = addr; StoreData = data;
    o    = int'(addr[1:0]);
    word = op == 3'd0 || op == 3'd5;
    half = op == 3'd1 || op == 3'd2 || op == 3'd6;
    byt  = op == 3'd3 || op == 3'd4 || op == 3'd7;
`ifdef MISALIGN_CHECK_EN
    mis = (word && o != 0) || (half && o % 2 == 1);
`else
    mis = 1'b0;
`endif
    w   = ref_mem[addr[7:2]];
    sh  = word ? 0 : half ? (o >= 2 ? 0 : 16) : 8 * (3 - o);
    lat = mis ? 1 : ((half || byt) && op >= 3'd5) ? 3 : 2;
    ld_prev  = ld_model;
    exp_mis  = mis;
    exp_addr = {addr[31:2], 2'b00};
    if (!mis && op <= 3'd4) begin
      v = word ? w : (w >> sh) & (half ? 32'hFFFF : 32'hFF);
      if (op == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      if (op == 3'd3 && v[7]) v = v | 32'hFFFFFF00;
      ld_model = v;
    end
    if (!mis && op >= 3'd5) begin
      m = word ? 32'hFFFFFFFF : (half ? 32'hFFFF : 32'hFF) << sh;
      exp_wdata = (w & ~m) | ((data << sh) & m);
      if (!abort) ref_mem[addr[7:2]] = exp_wdata;
    end
    acc      = cyc;
    done_cyc = acc + lat;
    rd_cyc   = (!mis && op != 3'd5) ? acc + 1 : -10;
    wr_cyc   = (!mis && op >= 3'd5) ? acc + lat - 1 : -10;
    chk("latency", 32'(lat), 32'(pin_lat));
    @(posedge Clk); #2;
    if (hold) begin Op = 3'd5; Addr = 32'h3C; StoreData = 32'hFFFFFFFF; end
    else Req = 1'b0;
    if (abort) begin
      Reset_n = 1'b0;
      @(posedge Clk); #2;
      Reset_n = 1'b1; Req = 1'b0;
      acc = -10; rd_cyc = -10; wr_cyc = -10; done_cyc = -10;
      ld_prev = '0; ld_model = '0; exp_mis = 1'b0;
      chk("abort_ready", 32'(Ready), 32'd1);
      chk("abort_done", 32'(Done), 32'd0);
      chk("abort_memaddress", MemAddress, 32'h0);
      chk("abort_memwritedata", MemWriteData, 32'h0);
      chk("abort_loaddata", LoadData, 32'h0);
      return;
    end
    for (int k = 0; k < 8 && cyc < done_cyc + 1; k++) begin @(posedge Clk); #2; end
    if (op <= 3'd4) chk("pin_loaddata", LoadData, pin);
    else chk("pin_memwritedata", MemWriteData, pin);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge Clk);
    #2;
    chk("rst_ready", 32'(Ready), 32'd1);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_loaddata", LoadData, 32'h0);
    chk("rst_misaligned", 32'(Misaligned), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_memaddress", MemAddress, 32'h0);
    chk("rst_memwritedata", MemWriteData, 32'h0);
    Reset_n = 1'b1;
    run = 1'b1;
    issue(3'd0, 32'h10, 32'h0, 0, 0, 32'h11223344, 2);
    issue(3'd3, 32'h20, 32'h0, 1, 0, 32'hFFFFFF80, 2);
    issue(3'd4, 32'h20, 32'h0, 1, 0, 32'h00000080, 2);
    issue(3'd1, 32'h22, 32'h0, 1, 0, 32'h00007F01, 2);
    issue(3'd1, 32'h20, 32'h0, 0, 0, 32'hFFFF80FF, 2);
    issue(3'd2, 32'h20, 32'h0, 0, 0, 32'h000080FF, 2);
    issue(3'd3, 32'h22, 32'h0, 0, 0, 32'h0000007F, 2);
    issue(3'd3, 32'h21, 32'h0, 0, 0, 32'hFFFFFFFF, 2);
    issue(3'd4, 32'h23, 32'h0, 0, 0, 32'h00000001, 2);
    issue(3'd7, 32'h11, 32'h000000AB, 0, 0, 32'h11AB3344, 3);
    issue(3'd0, 32'h10, 32'h0, 0, 0, 32'h11AB3344, 2);
    issue(3'd5, 32'h10, 32'h11223344, 0, 0, 32'h11223344, 2);
    issue(3'd6, 32'h12, 32'hDEADBEEF, 0, 0, 32'h1122BEEF, 3);
    issue(3'd5, 32'h14, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 2);
    issue(3'd0, 32'h14, 32'h0, 0, 0, 32'hCAFEF00D, 2);
    issue(3'd6, 32'h20, 32'h0000A5A5, 1, 0, 32'hA5A57F01, 3);
    issue(3'd7, 32'h23, 32'h00000077, 1, 0, 32'hA5A57F77, 3);
    issue(3'd0, 32'h20, 32'h0, 0, 0, 32'hA5A57F77, 2);
    issue(3'd0, 32'h14, 32'h0, 0, 0, 32'hCAFEF00D, 2);
`ifdef MISALIGN_CHECK_EN
    issue(3'd0, 32'h12, 32'h0, 0, 0, 32'hCAFEF00D, 1);
    issue(3'd2, 32'h23, 32'h0, 0, 0, 32'hCAFEF00D, 1);
`else
    issue(3'd0, 32'h12, 32'h0, 0, 0, 32'h1122BEEF, 2);
    issue(3'd2, 32'h23, 32'h0, 0, 0, 32'h00007F77, 2);
`endif
    issue(3'd7, 32'h10, 32'h0000005A, 1, 1, 32'h0, 3);
    repeat (3) begin @(posedge Clk); #2; end
    issue(3'd0, 32'h10, 32'h0, 0, 0, 32'h1122BEEF, 2);
    repeat (3) begin @(posedge Clk); #2; end
    for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
